// File: rtl/exec_unit_mc.sv
// Execute stage: forwarding muxes, immediate path, single-cycle ALU/shifts and an
// iterative shift-add multiplier, with valid/ready on both sides and a registered result.
module exec_unit_mc #(
  parameter int WIDTH = 16,
  parameter int NFWD  = 3,
  parameter int SELW  = $clog2(NFWD + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             op,
  input  logic [WIDTH-1:0]       sr1,
  input  logic [WIDTH-1:0]       sr2,
  input  logic [WIDTH-1:0]       imm,
  input  logic                   use_imm,
  input  logic [NFWD*WIDTH-1:0]  fwd_data,
  input  logic [SELW-1:0]        sr1_fwd_sel,
  input  logic [SELW-1:0]        sr2_fwd_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       result,
  output logic                   busy
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WAIT} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_AND, OP_NOT, OP_PASSB, OP_SLL, OP_SRL, OP_SRA, OP_MUL
  } op_e;

  state_e           state, state_next;
  logic [WIDTH-1:0] a, b, alu;
  logic [WIDTH-1:0] acc, acc_next, mcand, mplier;
  logic [SHW-1:0]   cnt;
  logic             accept, last, out_free, load;
  logic [WIDTH-1:0] load_val;

  // Select 0 or any value beyond NFWD falls back to the register-file operand.
  function automatic logic [WIDTH-1:0] fwdmux(input logic [WIDTH-1:0]      base,
                                               input logic [SELW-1:0]       sel,
                                               input logic [NFWD*WIDTH-1:0] fd);
    fwdmux = base;
    for (int unsigned k = 0; k < NFWD; k++)
      if (sel == SELW'(k + 1)) fwdmux = fd[k*WIDTH +: WIDTH];
  endfunction

  assign a = fwdmux(sr1, sr1_fwd_sel, fwd_data);
  assign b = use_imm ? imm : fwdmux(sr2, sr2_fwd_sel, fwd_data);

  always_comb begin
    alu = '0;
    unique case (op_e'(op))
      OP_ADD:   alu = a + b;
      OP_AND:   alu = a & b;
      OP_NOT:   alu = ~a;
      OP_PASSB: alu = b;
      OP_SLL:   alu = a << b[SHW-1:0];
      OP_SRL:   alu = a >> b[SHW-1:0];
      OP_SRA:   alu = WIDTH'($signed(a) >>> b[SHW-1:0]);
      OP_MUL:   alu = '0;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign last     = (state == S_MUL) && (cnt == SHW'(WIDTH - 1));
  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (accept && op == OP_MUL) state_next = S_MUL;
      S_MUL:  if (last) state_next = out_free ? S_IDLE : S_WAIT;
      S_WAIT: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_IDLE) && out_free;
    busy     = (state != S_IDLE);
    load     = 1'b0;
    load_val = alu;
    unique case (state)
      S_IDLE: load = accept && (op != OP_MUL);
      S_MUL: begin
        load     = last && out_free;
        load_val = acc_next;
      end
      S_WAIT: begin
        load     = out_ready;
        load_val = acc;
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      if (accept && op == OP_MUL) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end
      if (state == S_MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      if (load) begin
        result    <= load_val;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
